// File: rtl/inst_loader.sv
// Byte-stream program loader: 4-byte big-endian word-count header, then big-endian payload words
// written to instruction BRAM port A. Optional trailing checksum byte via INST_LOADER_CHECKSUM_EN.
module inst_loader #(
    parameter int unsigned MAX_WORDS = 16384,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [7:0]       data,
    input  logic             clear,
    output logic [31:0]      inst_addra,
    output logic [31:0]      inst_dina,
    output logic [3:0]       inst_wea,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] loaded_words
);

`ifdef INST_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {StHdr, StPayload, StCsum, StDone, StErr} state_e;
`else
    typedef enum logic [2:0] {StHdr, StPayload, StDone, StErr} state_e;
`endif

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [23:0]      hdr_q, hdr_d;
    logic [23:0]      word_q, word_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] lw_q, lw_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      din_q, din_d;
    logic [3:0]       wea_q, wea_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    logic [31:0]      hdr_full;
    logic [31:0]      word_full;
    logic [CNT_W-1:0] lw_inc;

    assign hdr_full  = {hdr_q, data};
    assign word_full = {word_q, data};
    assign lw_inc    = lw_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hdr_d   = hdr_q;
        word_d  = word_q;
        n_d     = n_q;
        lw_d    = lw_q;
        addr_d  = addr_q;
        din_d   = din_q;
        wea_d   = 4'h0;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
`ifdef INST_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        // clear wins over a coincident byte, which is dropped; BRAM port regs keep their values
        if (clear) begin
            state_d = StHdr;
            idx_d   = 2'd0;
            hdr_d   = 24'd0;
            lw_d    = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_d  = 8'd0;
`endif
        end else if (en) begin
            unique case (state_q)
                StHdr: begin
                    busy_d = 1'b1;
                    hdr_d  = hdr_full[23:0];
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (hdr_full > 32'(MAX_WORDS)) begin
                            state_d = StErr;
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                        end else if (hdr_full == 32'd0) begin
`ifdef INST_LOADER_CHECKSUM_EN
                            state_d = StCsum;
`else
                            state_d = StDone;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
`endif
                        end else begin
                            state_d = StPayload;
                            n_d     = hdr_full[CNT_W-1:0];
                        end
                    end
                end
                StPayload: begin
                    word_d = word_full[23:0];
                    idx_d  = idx_q + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
                    csum_d = csum_q + data;
`endif
                    if (idx_q == 2'd3) begin
                        wea_d  = 4'hF;
                        addr_d = 32'(lw_q) << 2;
                        din_d  = word_full;
                        lw_d   = lw_inc;
                        if (lw_inc == n_q) begin
`ifdef INST_LOADER_CHECKSUM_EN
                            state_d = StCsum;
`else
                            state_d = StDone;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
`endif
                        end
                    end
                end
`ifdef INST_LOADER_CHECKSUM_EN
                StCsum: begin
                    busy_d = 1'b0;
                    if (data == csum_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StHdr;
            idx_q   <= 2'd0;
            hdr_q   <= 24'd0;
            word_q  <= 24'd0;
            n_q     <= '0;
            lw_q    <= '0;
            addr_q  <= 32'd0;
            din_q   <= 32'd0;
            wea_q   <= 4'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hdr_q   <= hdr_d;
            word_q  <= word_d;
            n_q     <= n_d;
            lw_q    <= lw_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wea_q   <= wea_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign inst_addra   = addr_q;
    assign inst_dina    = din_q;
    assign inst_wea     = wea_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign loaded_words = lw_q;

endmodule
